// File: rtl/uart_dbg_pkg.sv
// rtl/uart_dbg_pkg.sv - shared defaults and LED mode encodings for the switch/LED debug block
package uart_dbg_pkg;

  localparam int DEB_CYCLES_DEF     = 100000;
  localparam int STRETCH_CYCLES_DEF = 5000000;

  typedef enum logic {
    LED_LIVE    = 1'b0,
    LED_LAST_WR = 1'b1
  } led_mode_e;

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - one-bit two-flop synchroniser followed by a mismatch-count debouncer
module debounce_cell
  import uart_dbg_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised level agrees with the accepted one restarts the window.
  always_comb begin
    sync_d   = {sync_q[0], din};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/sw_debug_debounce.sv
// rtl/sw_debug_debounce.sv - debounced switches/buttons with FIFO strobes and stretched LEDs
module sw_debug_debounce
  import uart_dbg_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter int STRETCH_CYCLES = STRETCH_CYCLES_DEF,
  parameter int LED_MODE       = int'(LED_LIVE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] switch,
  input  logic              RD,
  input  logic              WR,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_pulse,
  output logic              wr_pulse,
  output logic [DATA_W-1:0] LED,
  output logic              RD_LED,
  output logic              WR_LED
);

  localparam int NB = DATA_W + 2;
  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);

  logic [NB-1:0] raw;
  logic [NB-1:0] stable;
  logic          stable_rd, stable_wr;

  assign raw = {WR, RD, switch};

  for (genvar i = 0; i < NB; i++) begin : g_deb
    debounce_cell #(.DEB_CYCLES(DEB_CYCLES)) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw[i]),
      .dout (stable[i])
    );
  end

  assign stable_rd = stable[DATA_W];
  assign stable_wr = stable[DATA_W+1];

  logic              rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic              rd_pulse_q, rd_pulse_d, wr_pulse_q, wr_pulse_d;
  logic [SW-1:0]     rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic              rd_led_q, rd_led_d, wr_led_q, wr_led_d;
  logic [DATA_W-1:0] led_q, led_d;

  always_comb begin
    rd_prev_d  = stable_rd;
    wr_prev_d  = stable_wr;
    rd_pulse_d = stable_rd & ~rd_prev_q;
    wr_pulse_d = stable_wr & ~wr_prev_q;

    // A strobe reloads the stretch counter even while lit, so retriggers never leave a gap.
    rd_cnt_d = rd_cnt_q;
    if (rd_pulse_q)           rd_cnt_d = STRETCH_LOAD;
    else if (rd_cnt_q != '0)  rd_cnt_d = rd_cnt_q - SW'(1);
    wr_cnt_d = wr_cnt_q;
    if (wr_pulse_q)           wr_cnt_d = STRETCH_LOAD;
    else if (wr_cnt_q != '0)  wr_cnt_d = wr_cnt_q - SW'(1);

    rd_led_d = (rd_cnt_d != '0);
    wr_led_d = (wr_cnt_d != '0);

    led_d = led_q;
    if (LED_MODE == int'(LED_LAST_WR)) begin
      if (wr_pulse_q) led_d = stable[DATA_W-1:0];
    end else begin
      led_d = stable[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_led_q   <= 1'b0;
      wr_led_q   <= 1'b0;
      led_q      <= '0;
    end else begin
      rd_prev_q  <= rd_prev_d;
      wr_prev_q  <= wr_prev_d;
      rd_pulse_q <= rd_pulse_d;
      wr_pulse_q <= wr_pulse_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_led_q   <= rd_led_d;
      wr_led_q   <= wr_led_d;
      led_q      <= led_d;
    end
  end

  assign data_out = stable[DATA_W-1:0];
  assign rd_pulse = rd_pulse_q;
  assign wr_pulse = wr_pulse_q;
  assign LED      = led_q;
  assign RD_LED   = rd_led_q;
  assign WR_LED   = wr_led_q;

endmodule
